keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Parametrised matrix-keypad scanner for ROWS×COLS keypads. It drives one-hot column strobes at a programmable scan rate and synchronises and samples the row lines. Whole-frame results are debounced, and each new key press is delivered as an encoded code through a valid/ack handshake. It sits between the board keypad pins and the consumer logic (entry register, display driver), and adds debouncing, multi-key rejection and overrun reporting.

## Interface
- ROWS, 4, number of row inputs (≥2)
- COLS, 4, number of column strobes (≥2)
- SCAN_DIV, 450000, clk cycles each column stays driven (≥4)
- DEBOUNCE, 3, consecutive identical frame results needed to accept a state (≥1)
- clk  input  1  system clock; all logic on posedge
- rst  input  1  asynchronous, active-high reset
- filas  input  ROWS  row lines, active-high (pressed key at driven column reads 1)
- col  output  COLS  one-hot active-high column strobe
- code  output  CW=$clog2(ROWS*COLS)  encoded key, valid while key_valid=1
- key_valid  output  1  press event pending
- key_ack  input  1  consumer acknowledge
- key_down  output  1  debounced: exactly one key held
- multi  output  1  debounced: two or more keys held
- overrun  output  1  sticky: a press event was lost while key_valid=1

## Operation
- Row synchroniser: filas passes through a 2-flop synchroniser (filas_s).
- Tick counter: counts 0..SCAN_DIV-1 and wraps. tick=1 on the cycle the count equals SCAN_DIV-1.
- On tick:
  - filas_s is sampled for the currently driven column.
  - Then col shifts right by one; col[0] wraps to col[COLS-1].
  - Scan order is col[COLS-1] first. Column index c=0 means col[COLS-1] driven.
- Row index r=0 is filas[ROWS-1]. Key code = c*ROWS + r.
  - Default 4×4: col=1000, filas=1000 gives code 0; col=0001, filas=0001 gives code 15.
- Frame accumulation over the COLS ticks of a frame:
  - Count of set sampled bits, saturating at 2.
  - Code of the last set bit found.
- Frame end is the tick of column c=COLS-1. Frame result: NONE (0 keys), ONE(code) (1 key), MULTI (≥2 keys).
- Debounce:
  - If the frame result equals the previous frame result (including code for ONE), the stability count increments, saturating at DEBOUNCE. Otherwise it resets to 1.
  - A result is accepted when the stability count reaches DEBOUNCE.
- Accepted-state FSM, states IDLE, HELD, MULTI; reset to IDLE:
  - IDLE → HELD on accepted ONE(k): press event k.
  - IDLE → MULTI on accepted MULTI.
  - HELD → IDLE on accepted NONE.
  - HELD → MULTI on accepted MULTI.
  - HELD → HELD on accepted ONE(j), j≠k: press event j (rollover).
  - MULTI → IDLE on accepted NONE.
  - MULTI → HELD on accepted ONE(k): no event (the key was already down).
- key_down=1 in HELD. multi=1 in MULTI.
- Handshake for a press event:
  - If key_valid=0: code←k and key_valid←1.
  - If key_valid=1: the event is dropped, code keeps its old value, and overrun←1.
- key_valid and code hold stable until a clk edge with key_ack=1. key_valid is 0 from the next cycle on, and overrun clears on the same edge.
- Simultaneous ack and new event on the same edge: the new event is loaded (key_valid stays 1, code←k) and overrun is not set.
- key_ack while key_valid=0 is ignored.

## Timing
- Reset values (asynchronous on rst):
  - col={1'b1,{COLS-1{1'b0}}}; code=0; key_valid=0; key_down=0; multi=0; overrun=0.
  - Tick counter, frame accumulators, stability count and synchroniser all 0.
- Scan: each column is driven for exactly SCAN_DIV cycles. Frame period = COLS*SCAN_DIV cycles.
- Sampling: filas must be stable ≥3 cycles before the tick to be seen (2 synchroniser cycles plus the sample edge).
- FSM outputs, key_valid and code update on the clk edge following the frame-end tick (1-cycle registered latency).
- Press latency, from first frame fully seeing the key: DEBOUNCE frames + 1 cycle. A mid-frame press can add up to one more frame.
- Release latency: same rule.
- rst mid-scan or mid-handshake: immediate return to reset values. Scanning restarts at col[COLS-1] with a fresh frame. A pending event is lost and no overrun is set.

## Test plan
Parameters for all scenarios: ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=2; frame = 16 cycles.
- Reset/scan:
  - Stimulus: hold rst; release; filas=0.
  - Required: col=1000 after reset; sequence 1000→0100→0010→0001→1000 changing every 4 cycles; key_valid, key_down and multi stay 0.
- Single press with ack:
  - Stimulus: assert filas=0100 only while col=0010 (key c=2, r=1).
  - Required: code=9, key_valid=1 within 3 frames + 1 cycle, key_down=1.
  - Stimulus: key_ack for 1 cycle. Required: key_valid=0 next cycle. Release: key_down=0 after ≥2 frames.
- Bounce rejection:
  - Stimulus: key present in alternating frames only.
  - Required: key_valid never asserts. Key held steadily for 2 frames → event code issued.
- Multi-key:
  - Stimulus: codes 0 and 5 held together.
  - Required: multi=1, key_valid stays 0. Release code 5, keep 0: key_down=1, multi=0, no event.
- Overrun and rollover:
  - Stimulus: press code 3, no ack; then roll to code 12.
  - Required: code stays 3, overrun=1. key_ack clears key_valid and overrun.
  - Stimulus: ack asserted on the same edge as a new event. Required: code=new value, key_valid=1, overrun=0.
- Reset mid-handshake:
  - Stimulus: key_valid=1 at code 7, pulse rst asynchronously between edges.
  - Required: all outputs return to reset values immediately; with the key still held, a new event code 7 is issued after 2 frames.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: ROWSxCOLS matrix keypad scanner with frame debounce,
// multi-key rejection and a valid/ack press-event handshake.
// Ports:
//   clk, rst       clock, async active-high reset
//   filas          row lines (active-high)
//   col            one-hot column strobe, col[COLS-1] driven first
//   code           encoded key (c*ROWS + r), valid while key_valid
//   key_valid      press event pending; key_ack consumes it
//   key_down       debounced: exactly one key held
//   multi          debounced: two or more keys held
//   overrun        sticky: an event was dropped while key_valid=1
module keypad_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 450000,
    parameter int DEBOUNCE = 3,
    localparam int CW      = $clog2(ROWS * COLS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ROWS-1:0] filas,
    output logic [COLS-1:0] col,
    output logic [CW-1:0]   code,
    output logic            key_valid,
    input  logic            key_ack,
    output logic            key_down,
    output logic            multi,
    output logic            overrun
);

    localparam int TW  = $clog2(SCAN_DIV);
    localparam int CIW = $clog2(COLS);
    localparam int SW  = $clog2(DEBOUNCE + 1);

    // Frame result kinds; numerically equal to the saturated key count.
    localparam logic [1:0] R_NONE  = 2'd0;
    localparam logic [1:0] R_ONE   = 2'd1;
    localparam logic [1:0] R_MULTI = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HELD,
        S_MULTI
    } state_t;

    logic [ROWS-1:0] r_sync1;
    logic [ROWS-1:0] r_sync2;
    logic [TW-1:0]   r_tcnt;
    logic [COLS-1:0] r_col;
    logic [CIW-1:0]  r_cidx;
    logic [1:0]      r_acc_n;
    logic [CW-1:0]   r_acc_code;
    logic [1:0]      r_prev_kind;
    logic [CW-1:0]   r_prev_code;
    logic [SW-1:0]   r_stab;
    logic            r_fe;
    state_t          r_state;
    state_t          w_state_nx;
    logic [CW-1:0]   r_held;
    logic [CW-1:0]   w_held_nx;
    logic            r_valid;
    logic [CW-1:0]   r_code;
    logic            r_ovr;

    logic            w_tick;
    logic            w_fend;
    logic [1:0]      w_col_n;
    logic [CW-1:0]   w_col_code;
    logic [2:0]      w_sum;
    logic [1:0]      w_kind;
    logic [CW-1:0]   w_frm_code;
    logic            w_same;
    logic            w_accept;
    logic            w_evt;

    assign w_tick = (r_tcnt == TW'(SCAN_DIV - 1));
    assign w_fend = w_tick && (r_cidx == CIW'(COLS - 1));

    // Keys seen on the current column: count (saturating at 2) and the
    // code of the last set row, scanning r=0 (filas[ROWS-1]) upward.
    always_comb begin
        w_col_n    = 2'd0;
        w_col_code = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (r_sync2[ROWS-1-r]) begin
                if (w_col_n != 2'd2) begin
                    w_col_n = w_col_n + 2'd1;
                end
                w_col_code = CW'(int'(r_cidx) * ROWS + r);
            end
        end
    end

    assign w_sum      = {1'b0, r_acc_n} + {1'b0, w_col_n};
    assign w_kind     = (w_sum >= 3'd2) ? R_MULTI : w_sum[1:0];
    assign w_frm_code = (w_col_n != 2'd0) ? w_col_code : r_acc_code;
    assign w_same     = (w_kind == r_prev_kind) &&
                        ((w_kind != R_ONE) || (w_frm_code == r_prev_code));

    // Scan, frame accumulation and debounce.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_tcnt      <= '0;
            r_col       <= {1'b1, {(COLS-1){1'b0}}};
            r_cidx      <= '0;
            r_acc_n     <= '0;
            r_acc_code  <= '0;
            r_prev_kind <= R_NONE;
            r_prev_code <= '0;
            r_stab      <= '0;
            r_fe        <= 1'b0;
        end else begin
            r_sync1 <= filas;
            r_sync2 <= r_sync1;
            r_fe    <= w_fend;
            if (w_tick) begin
                r_tcnt <= '0;
                r_col  <= {r_col[0], r_col[COLS-1:1]};
                if (w_fend) begin
                    r_cidx      <= '0;
                    r_acc_n     <= '0;
                    r_acc_code  <= '0;
                    r_prev_kind <= w_kind;
                    r_prev_code <= w_frm_code;
                    if (w_same) begin
                        if (r_stab != SW'(DEBOUNCE)) begin
                            r_stab <= r_stab + SW'(1);
                        end
                    end else begin
                        r_stab <= SW'(1);
                    end
                end else begin
                    r_cidx     <= r_cidx + CIW'(1);
                    r_acc_n    <= w_kind;
                    r_acc_code <= w_frm_code;
                end
            end else begin
                r_tcnt <= r_tcnt + TW'(1);
            end
        end
    end

    // The debounced result is registered at frame end and acted on one
    // cycle later.
    assign w_accept = r_fe && (r_stab == SW'(DEBOUNCE));

    always_comb begin
        w_state_nx = r_state;
        w_held_nx  = r_held;
        w_evt      = 1'b0;
        if (w_accept) begin
            case (r_state)
                S_IDLE: begin
                    if (r_prev_kind == R_ONE) begin
                        w_state_nx = S_HELD;
                        w_held_nx  = r_prev_code;
                        w_evt      = 1'b1;
                    end else if (r_prev_kind == R_MULTI) begin
                        w_state_nx = S_MULTI;
                    end
                end
                S_HELD: begin
                    if (r_prev_kind == R_NONE) begin
                        w_state_nx = S_IDLE;
                    end else if (r_prev_kind == R_MULTI) begin
                        w_state_nx = S_MULTI;
                    end else if (r_prev_code != r_held) begin
                        w_held_nx = r_prev_code;
                        w_evt     = 1'b1;
                    end
                end
                S_MULTI: begin
                    if (r_prev_kind == R_NONE) begin
                        w_state_nx = S_IDLE;
                    end else if (r_prev_kind == R_ONE) begin
                        // Remaining key was already down: no event.
                        w_state_nx = S_HELD;
                        w_held_nx  = r_prev_code;
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_held  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_held  <= w_held_nx;
        end
    end

    // Event handshake; a same-edge ack frees the slot for the new event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_code  <= '0;
            r_ovr   <= 1'b0;
        end else begin
            if (r_valid && key_ack) begin
                r_valid <= 1'b0;
                r_ovr   <= 1'b0;
            end
            if (w_evt) begin
                if (!r_valid || key_ack) begin
                    r_valid <= 1'b1;
                    r_code  <= r_prev_code;
                end else begin
                    r_ovr <= 1'b1;
                end
            end
        end
    end

    assign col       = r_col;
    assign code      = r_code;
    assign key_valid = r_valid;
    assign key_down  = (r_state == S_HELD);
    assign multi     = (r_state == S_MULTI);
    assign overrun   = r_ovr;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad emulation driven by a key set, checked per
// frame against a frame-level behavioural model.
module tb_keypad_scanner;

    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 2;
    localparam int CW       = 4;
    localparam int FRAME    = COLS * SCAN_DIV;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [ROWS-1:0] filas;
    logic [COLS-1:0] col;
    logic [CW-1:0]   code;
    logic            key_valid;
    logic            key_ack = 1'b0;
    logic            key_down;
    logic            multi;
    logic            overrun;

    logic [15:0]     keys = '0;

    int n_chk  = 0;
    int n_fail = 0;
    int edge_n = 0;

    // Model: frame results (-1 none, -2 multi, else key code).
    int hist[$];
    bit pend;
    int m_state;
    int m_held;
    bit m_valid;
    int m_code;
    bit m_ovr;

    keypad_scanner #(
        .ROWS(ROWS),
        .COLS(COLS),
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .filas(filas),
        .col(col),
        .code(code),
        .key_valid(key_valid),
        .key_ack(key_ack),
        .key_down(key_down),
        .multi(multi),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Physical keypad: key c*ROWS+r connects col[COLS-1-c] to filas[ROWS-1-r].
    always_comb begin
        filas = '0;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                if (col[COLS-1-c] && keys[c*ROWS+r]) begin
                    filas[ROWS-1-r] = 1'b1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)",
                     tag, got, exp, edge_n);
        end
    endtask

    function automatic logic [15:0] kmask(input int i);
        logic [15:0] one;
        one = 16'd1;
        return one << i;
    endfunction

    function automatic int frame_res(input logic [15:0] k);
        int n;
        n = $countones(k);
        if (n == 0) return -1;
        if (n > 1) return -2;
        for (int i = 0; i < 16; i++) begin
            if (k[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        hist.delete();
        pend    = 0;
        m_state = 0;
        m_held  = 0;
        m_valid = 0;
        m_code  = 0;
        m_ovr   = 0;
        edge_n  = 0;
    endtask

    task automatic step();
        logic [3:0] exp_col;
        exp_col = 4'b1000;
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        exp_col = exp_col >> ((edge_n / SCAN_DIV) % COLS);
        check("col", 32'(col), 32'(exp_col));
    endtask

    // Edge right after a frame end: accept the last result if stable.
    task automatic model_edge1(input bit ack);
        bit evt;
        int k;
        int res;
        bit stable;
        evt = 0;
        k   = 0;
        if (pend) begin
            pend   = 0;
            res    = hist[$];
            stable = (hist.size() >= DEBOUNCE);
            for (int i = 0; i < DEBOUNCE && stable; i++) begin
                if (hist[hist.size()-1-i] != res) stable = 0;
            end
            if (stable) begin
                if (m_state == 0) begin
                    if (res >= 0) begin
                        m_state = 1; m_held = res; evt = 1; k = res;
                    end else if (res == -2) begin
                        m_state = 2;
                    end
                end else if (m_state == 1) begin
                    if (res == -1) m_state = 0;
                    else if (res == -2) m_state = 2;
                    else if (res != m_held) begin
                        m_held = res; evt = 1; k = res;
                    end
                end else begin
                    if (res == -1) m_state = 0;
                    else if (res >= 0) begin
                        m_state = 1; m_held = res;
                    end
                end
            end
        end
        if (evt) begin
            if (!m_valid || ack) begin
                m_valid = 1; m_code = k; m_ovr = 0;
            end else begin
                m_ovr = 1;
            end
        end else if (ack && m_valid) begin
            m_valid = 0; m_ovr = 0;
        end
    endtask

    task automatic check_outputs();
        check("key_valid", 32'(key_valid), 32'(m_valid));
        check("code", 32'(code), 32'(m_code));
        check("key_down", 32'(key_down), 32'(m_state == 1));
        check("multi", 32'(multi), 32'(m_state == 2));
        check("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_col", 32'(col), 32'(4'b1000));
        check("rst_code", 32'(code), 32'd0);
        check("rst_valid", 32'(key_valid), 32'd0);
        check("rst_down", 32'(key_down), 32'd0);
        check("rst_multi", 32'(multi), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One full frame with a fixed key set; optional ack on the result edge,
    // mid-frame ack, or reset pulse after edge rst_at of the frame.
    task automatic run_frame(input logic [15:0] k, input bit ack_a,
                             input bit ack_m, input int rst_at);
        keys    = k;
        key_ack = ack_a;
        step();
        key_ack = 1'b0;
        model_edge1(ack_a);
        check_outputs();
        for (int e = 2; e <= FRAME; e++) begin
            if (e == 8) key_ack = ack_m;
            step();
            if (e == 8) begin
                key_ack = 1'b0;
                if (ack_m && m_valid) begin
                    m_valid = 0; m_ovr = 0;
                end
                check("mid_valid", 32'(key_valid), 32'(m_valid));
                check("mid_ovr", 32'(overrun), 32'(m_ovr));
            end
            if (e == rst_at) begin
                pulse_reset();
                return;
            end
        end
        hist.push_back(frame_res(k));
        while (hist.size() > DEBOUNCE) void'(hist.pop_front());
        pend = 1;
    endtask

    initial begin
        int nk;
        int len;
        int ra;
        bit aa;
        bit am;
        logic [15:0] k;

        repeat (2) @(negedge clk);
        check("init_col", 32'(col), 32'(4'b1000));
        check("init_valid", 32'(key_valid), 32'd0);
        check("init_code", 32'(code), 32'd0);
        rst = 1'b0;
        model_reset();

        // idle scan
        repeat (3) run_frame('0, 0, 0, 0);
        // single press, code 9, ack, release
        run_frame(kmask(9), 0, 0, 0);
        run_frame(kmask(9), 0, 0, 0);
        run_frame(kmask(9), 0, 1, 0);
        repeat (3) run_frame('0, 0, 0, 0);
        // bounce, then steady
        repeat (3) begin
            run_frame(kmask(4), 0, 0, 0);
            run_frame('0, 0, 0, 0);
        end
        run_frame(kmask(4), 0, 0, 0);
        run_frame(kmask(4), 0, 0, 0);
        run_frame(kmask(4), 0, 1, 0);
        run_frame('0, 0, 0, 0);
        run_frame('0, 0, 0, 0);
        // multi-key, then one released
        repeat (3) run_frame(kmask(0) | kmask(5), 0, 0, 0);
        repeat (3) run_frame(kmask(0), 0, 0, 0);
        repeat (2) run_frame('0, 0, 0, 0);
        // overrun via rollover, ack, then ack with simultaneous event
        repeat (3) run_frame(kmask(3), 0, 0, 0);
        repeat (3) run_frame(kmask(12), 0, 0, 0);
        run_frame(kmask(12), 0, 1, 0);
        repeat (2) run_frame(kmask(5), 0, 0, 0);
        repeat (2) run_frame(kmask(7), 0, 0, 0);
        repeat (2) run_frame(kmask(6), 0, 0, 0);
        run_frame(kmask(6), 1, 0, 0);
        run_frame('0, 0, 1, 0);
        repeat (2) run_frame('0, 0, 0, 0);
        // reset mid-handshake with key held
        repeat (3) run_frame(kmask(7), 0, 0, 0);
        run_frame(kmask(7), 0, 0, 6);
        repeat (3) run_frame(kmask(7), 0, 0, 0);

        // random key sets, acks and resets
        for (int s = 0; s < 80; s++) begin
            nk = $urandom_range(0, 2);
            k  = '0;
            for (int i = 0; i < nk; i++) begin
                k = k | kmask($urandom_range(0, 15));
            end
            len = $urandom_range(1, 3);
            for (int f = 0; f < len; f++) begin
                aa = ($urandom_range(0, 3) == 0);
                am = ($urandom_range(0, 3) == 0);
                ra = ($urandom_range(0, 29) == 0) ? $urandom_range(2, 15) : 0;
                run_frame(k, aa, am, ra);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
